// File: rtl/led_peak_meter.sv
// led_peak_meter: log-scaled stereo level meter with peak hold and timed decay on 8 LEDs
module led_peak_meter #(
    parameter int HOLD_SAMPLES  = 4800,
    parameter int DECAY_SAMPLES = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [15:0] lft_out,
    input  logic [15:0] rht_out,
    input  logic        mode,
    output logic [7:0]  LED
);
    localparam int HW = $clog2(HOLD_SAMPLES + 1);
    localparam int DW = (DECAY_SAMPLES > 1) ? $clog2(DECAY_SAMPLES) : 1;
    localparam logic [HW-1:0] HOLD_INIT  = HW'(HOLD_SAMPLES);
    localparam logic [DW-1:0] DECAY_LAST = DW'(DECAY_SAMPLES - 1);

    typedef enum logic [1:0] {IDLE, HOLD, DECAY} state_t;

    logic          valid_q;
    logic          ev0_q;
    logic [15:0]   lft_q;
    logic [15:0]   rht_q;
    logic          ev1_q;
    logic [3:0]    lvl_q;
    state_t        state_q;
    logic [3:0]    pk_q;
    logic [3:0]    lvl_r_q;
    logic [HW-1:0] hold_cnt_q;
    logic [DW-1:0] decay_cnt_q;
    logic [7:0]    led_q;
    logic [14:0]   mag_l;
    logic [14:0]   mag_r;
    logic [14:0]   mag;

    // |x| with -32768 saturated to 32767
    function automatic logic [14:0] abs15(input logic [15:0] x);
        logic [15:0] n;
        n = 16'd0 - x;
        return (x == 16'h8000) ? 15'h7fff : (x[15] ? n[14:0] : x[14:0]);
    endfunction

    // number of octave thresholds 128..16384 reached by m
    function automatic logic [3:0] quant(input logic [14:0] m);
        logic [3:0] c;
        c = 4'd0;
        for (int k = 1; k <= 8; k++)
            if (m >= 15'(1 << (k + 6))) c = c + 4'd1;
        return c;
    endfunction

    function automatic logic [7:0] bar(input logic [3:0] n);
        logic [8:0] t;
        t = (9'd1 << n) - 9'd1;
        return t[7:0];
    endfunction

    function automatic logic [7:0] dot(input logic [3:0] n);
        return (n == 4'd0) ? 8'd0 : (8'd1 << (n - 4'd1));
    endfunction

    assign mag_l = abs15(lft_q);
    assign mag_r = abs15(rht_q);
    assign mag   = (mag_l > mag_r) ? mag_l : mag_r;
    assign LED   = led_q;

    // stage 0: rising-edge detect on valid and capture of the sample pair
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b1;
            ev0_q   <= 1'b0;
            lft_q   <= '0;
            rht_q   <= '0;
        end else begin
            valid_q <= valid;
            ev0_q   <= valid & ~valid_q;
            lft_q   <= lft_out;
            rht_q   <= rht_out;
        end
    end

    // stage 1: register the quantized level of the louder channel
    always_ff @(posedge clk) begin
        if (rst) begin
            ev1_q <= 1'b0;
            lvl_q <= '0;
        end else begin
            ev1_q <= ev0_q;
            lvl_q <= quant(mag);
        end
    end

    // stage 2: peak FSM; a level at or above the peak restarts the hold
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pk_q        <= '0;
            lvl_r_q     <= '0;
            hold_cnt_q  <= '0;
            decay_cnt_q <= '0;
        end else if (ev1_q) begin
            lvl_r_q <= lvl_q;
            if (lvl_q >= pk_q && lvl_q != 4'd0) begin
                pk_q        <= lvl_q;
                hold_cnt_q  <= HOLD_INIT;
                decay_cnt_q <= '0;
                state_q     <= HOLD;
            end else begin
                case (state_q)
                    HOLD: begin
                        hold_cnt_q <= (hold_cnt_q != '0) ? hold_cnt_q - HW'(1) : hold_cnt_q;
                        if (hold_cnt_q <= HW'(1)) begin
                            state_q     <= DECAY;
                            decay_cnt_q <= '0;
                        end
                    end
                    DECAY: begin
                        if (decay_cnt_q == DECAY_LAST) begin
                            decay_cnt_q <= '0;
                            pk_q        <= (pk_q != 4'd0) ? pk_q - 4'd1 : pk_q;
                            if (pk_q <= 4'd1) state_q <= IDLE;
                        end else begin
                            decay_cnt_q <= decay_cnt_q + DW'(1);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // stage 3: LED drive, recomputed every cycle from registered state
    always_ff @(posedge clk) begin
        if (rst) led_q <= '0;
        else     led_q <= mode ? (bar(lvl_r_q) | dot(pk_q)) : bar(pk_q);
    end
endmodule

// File: tb/tb_led_peak_meter.sv
// tb_led_peak_meter: directed checks of reset, latency, quantizing, hold/decay, dot mode and event detect
module tb_led_peak_meter;
    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [15:0] lft;
    logic [15:0] rht;
    logic        mode;
    logic [7:0]  led;
    int          checks = 0;
    int          errors = 0;

    led_peak_meter #(.HOLD_SAMPLES(4), .DECAY_SAMPLES(2)) dut (
        .clk(clk), .rst(rst), .valid(valid), .lft_out(lft), .rht_out(rht),
        .mode(mode), .LED(led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic send(input logic [15:0] l, input logic [15:0] r);
        lft = l;
        rht = r;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; valid = 1'b1; lft = 16'h4000; rht = 16'h0000; mode = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("reset_led", led, 8'h00);
        end
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("reset_release_led", led, 8'h00);
        end
        chk("reset_pk", dut.pk_q, 4'd0);

        valid = 1'b0;
        @(negedge clk);
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        chk("lat_n", led, 8'h00);
        @(negedge clk);
        chk("lat_n1", led, 8'h00);
        @(negedge clk);
        chk("lat_n2", led, 8'h00);
        @(negedge clk);
        chk("lat_n3", led, 8'hff);

        do_reset();
        send(16'h8000, 16'h0000);
        chk("sat_neg_full", led, 8'hff);
        do_reset();
        send(16'h0000, 16'hff38);
        chk("rht_minus200", led, 8'h01);
        do_reset();
        send(16'h0000, 16'h007f);
        chk("rht_127", led, 8'h00);

        do_reset();
        send(16'h4000, 16'h0000);
        for (int i = 1; i <= 20; i++) begin
            send(16'h0000, 16'h0000);
            if (i <= 5) chk("hold_ff", led, 8'hff);
            if (i == 6) chk("decay_7f", led, 8'h7f);
            if (i == 8) chk("decay_3f", led, 8'h3f);
        end
        chk("decay_end_led", led, 8'h00);
        chk("decay_end_idle", dut.state_q, 2'd0);

        do_reset();
        send(16'h4000, 16'h0000);
        repeat (14) send(16'h0000, 16'h0000);
        chk("var_pk3_led", led, 8'h07);
        send(16'h0400, 16'h0000);
        chk("var_pk4", dut.pk_q, 4'd4);
        chk("var_led", led, 8'h0f);
        chk("var_hold_state", dut.state_q, 2'd1);
        chk("var_hold_cnt", dut.hold_cnt_q, 3'd4);

        do_reset();
        mode = 1'b1;
        send(16'h4000, 16'h0000);
        chk("dot_full", led, 8'hff);
        send(16'h0100, 16'h0000);
        chk("dot_83", led, 8'h83);
        mode = 1'b0;
        #1 chk("mode_not_yet", led, 8'h83);
        @(negedge clk);
        chk("mode_switch", led, 8'hff);

        do_reset();
        lft = 16'h4000; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        repeat (2) @(negedge clk);
        lft = 16'h0100; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        repeat (2) @(negedge clk);
        lft = 16'h0800; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("b2b_pk", dut.pk_q, 4'd8);
        chk("b2b_lvl_r", dut.lvl_r_q, 4'd5);
        chk("b2b_hold_cnt", dut.hold_cnt_q, 3'd2);
        mode = 1'b1;
        @(negedge clk);
        chk("b2b_dot_led", led, 8'h9f);

        do_reset();
        mode = 1'b0;
        send(16'h4000, 16'h0000);
        lft = 16'h0000; valid = 1'b1;
        repeat (10) @(negedge clk);
        valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("stretch_hold_cnt", dut.hold_cnt_q, 3'd3);
        chk("stretch_state", dut.state_q, 2'd1);
        chk("stretch_led", led, 8'hff);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/led_peak_meter.md
# led_peak_meter

Output-side level meter for the 5-channel stereo equalizer. It consumes the post-equalizer stereo samples (`lft_out`, `rht_out`) on the codec `valid` strobe and drives the 8 board LEDs. The meter uses a log-scaled bar with peak-hold and timed decay, so the display follows actual audio level rather than only the volume pot.

## Interface
Parameters:
- `HOLD_SAMPLES`, default 4800: sample events a peak is held before decay starts (about 100 ms at 48 kHz). Must be ≥1.
- `DECAY_SAMPLES`, default 480: sample events per one-LED decay step. Must be ≥1.

Ports:
- `clk` in 1: system clock (50 MHz).
- `rst` in 1: reset, synchronous, active-high.
- `valid` in 1: sample-ready level from the codec interface. A rising edge marks one new sample pair.
- `lft_out` in 16: left sample, signed two's complement.
- `rht_out` in 16: right sample, signed two's complement.
- `mode` in 1: 0 = peak bar, 1 = live bar plus peak dot.
- `LED` out 8: active-high LED drive, registered.

## Operation
- **Event detect:** `valid_q` holds `valid` delayed one cycle. An event occurs when `valid`=1 and `valid_q`=0. Holding `valid` high for any number of cycles produces one event.
- **Magnitude:** `|x|` of each channel, 15-bit unsigned. −32768 saturates to 32767. `mag = max(|lft|,|rht|)`.
- **Quantize:** `lvl` (0..8) = number of k in 1..8 with `mag ≥ 2^(k+6)`.
  - Thresholds are 128, 256, 512, 1024, 2048, 4096, 8192, 16384.
  - `mag < 128` gives 0. `mag ≥ 16384` gives 8.
- **Peak FSM:** states IDLE, HOLD, DECAY. Registers: `pk` (4 bits), `hold_cnt`, `decay_cnt`. The FSM updates only on the registered event.
  - Any state, `lvl ≥ pk` and `lvl ≠ 0`: `pk ← lvl`, `hold_cnt ← HOLD_SAMPLES`, `decay_cnt ← 0`, go to HOLD. Equal level restarts the hold.
  - IDLE, `lvl = 0`: stay in IDLE.
  - HOLD, `lvl < pk`: `hold_cnt` decrements. When it reaches 0, go to DECAY with `decay_cnt = 0`.
  - DECAY, `lvl < pk`:
    - If `decay_cnt = DECAY_SAMPLES−1`: `pk` decrements and `decay_cnt ← 0`. Go to IDLE when the new `pk` is 0.
    - Otherwise `decay_cnt` increments.
- **Display:** `bar(n) = (1<<n)−1`. `dot(n)` = 0 if n = 0, else `1<<(n−1)`. `lvl_r` is the last event's `lvl`.
  - `mode`=0: `LED ← bar(pk)`.
  - `mode`=1: `LED ← bar(lvl_r) | dot(pk)`.
  - `LED` is recomputed every cycle from registered state.

## Timing
- Stage 0: the event is detected at clock edge N, where `valid` is first sampled 1 and `valid_q` is 0.
- Stage 1 (edge N+1): the sample pair is captured and `mag`/`lvl` are registered. Inputs must be stable at edge N.
- Stage 2 (edge N+2): `pk`, `lvl_r`, counters and FSM state update.
- Stage 3 (edge N+3): `LED` is updated. Total event-to-LED latency is 3 cycles.
- A `mode` change is reflected on `LED` 1 cycle later.
- Events closer than 3 cycles apart must still each be processed in order; the pipeline is fully pipelined.
- **Reset** (`rst` high at an edge):
  - Cleared to 0: `LED`, `pk`, `lvl_r`, `hold_cnt`, `decay_cnt`, pipeline valid flags. State goes to IDLE.
  - `valid_q` is set to 1, so `valid` held high across reset release generates no event.
- Reset asserted mid-pipeline discards in-flight samples. Reset has priority over every event.
- **Counter widths:** `$clog2(HOLD_SAMPLES+1)` and `$clog2(DECAY_SAMPLES)` (minimum 1). Counters never wrap: `hold_cnt` stops at 0 and `decay_cnt` at `DECAY_SAMPLES−1`.
- **`pk` bounds:** never exceeds 8 and never decrements below 0.

## Test plan
- **Reset:** drive `rst`=1 for 2 cycles with `valid`=1, then release with `valid` still 1 for 5 cycles. Required: `LED`=0x00 throughout and no event.
- **Latency/full scale:** `mode`=0, `lft`=0x4000, `rht`=0, one `valid` edge. Required: `LED`=0x00 through N+2 and `LED`=0xFF at edge N+3.
- **Saturation/sign:** the following each start from a fresh reset.
  - `lft`=0x8000: `LED`=0xFF.
  - `lft`=0, `rht`=0xFF38 (−200), giving `lvl` 1: `LED`=0x01.
  - `rht`=0x007F (127): `LED`=0x00.
- **Hold/decay:** `HOLD_SAMPLES`=4, `DECAY_SAMPLES`=2. One 0x4000 sample, then zero samples.
  - `LED` stays 0xFF through zero samples 1–5.
  - `LED`=0x7F after zero sample 6, then 0x3F after sample 8.
  - `LED`=0x00 and state IDLE after sample 20.
  - Variant: inject `lft`=0x0400 (lvl 4) at zero sample 15, while `pk`=3. Required: `pk`=4, state HOLD, hold restarted.
- **Dot mode:** `mode`=1, peak 0x4000, then `lft`=0x0100 (lvl 2) within the hold. Required: `LED`=0x83. Switching `mode` to 0 gives `LED`=0xFF one cycle later.
- **Back-to-back and stretched valid:**
  - Events 3 cycles apart with levels 8, 2, 5. Required: `pk`=8 and `lvl_r`=5; nothing dropped.
  - `valid` held high for 10 cycles. Required: exactly one event.
